// File: rtl/lsu_mem_unit.sv
// Load/store unit: computes the effective address, sends one word-aligned
// bus access per legal micro-op and reports a one-cycle completion with
// the load result or the effective address. Misaligned accesses finish
// without touching the bus. Stuck accesses are aborted after TIMEOUT cycles.
module lsu_mem_unit #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clock_in,
    input  logic              reset_in,
    input  logic              enable_in,
    input  logic [3:0]        uop_in,
    input  logic [31:0]       a_data_in,
    input  logic [31:0]       b_data_in,
    input  logic [31:0]       st_data_in,
    output logic              busy_out,
    output logic              done_out,
    output logic [31:0]       res_data_out,
    output logic              misalign_out,
    output logic              err_out,
    output logic              mem_req_out,
    output logic              mem_we_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic [31:0]       mem_wdata_out,
    output logic [3:0]        mem_wstrb_out,
    input  logic              mem_ack_in,
    input  logic [31:0]       mem_rdata_in
);

    localparam logic [3:0] UOP_LB  = 4'b0001;
    localparam logic [3:0] UOP_LH  = 4'b0010;
    localparam logic [3:0] UOP_LW  = 4'b0011;
    localparam logic [3:0] UOP_LBU = 4'b0101;
    localparam logic [3:0] UOP_LHU = 4'b0110;
    localparam logic [3:0] UOP_SB  = 4'b1001;
    localparam logic [3:0] UOP_SH  = 4'b1010;
    localparam logic [3:0] UOP_SW  = 4'b1100;

    // The counter reaches this value in the last REQ cycle before an abort.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [31:0] ea_in;
    logic        legal_in;
    logic        misalign_in;
    logic        store_in;
    logic        accept;
    logic        timeout_hit;
    logic [3:0]  wstrb_in;
    logic [31:0] wdata_in;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_res;

    logic [3:0]  uop_q;
    logic [31:0] ea_q;
    logic [7:0]  tcount;
    logic        misalign_q;
    logic        err_q;
    logic [31:0] res_q;
    logic        we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;

    // Address sum wraps at 32 bits; overflow is not an error.
    assign ea_in = a_data_in + b_data_in;

    assign accept      = (state == IDLE) && enable_in && legal_in;
    assign timeout_hit = (tcount == TIMEOUT_LAST);

    assign busy_out      = (state != IDLE);
    assign done_out      = (state == DONE);
    assign mem_req_out   = (state == REQ);
    assign misalign_out  = (state == DONE) && misalign_q;
    assign err_out       = (state == DONE) && err_q;
    assign res_data_out  = res_q;
    assign mem_we_out    = we_q;
    assign mem_addr_out  = addr_q;
    assign mem_wdata_out = wdata_q;
    assign mem_wstrb_out = wstrb_q;

    // Decode the incoming micro-op: legality, direction and alignment.
    always_comb begin
        legal_in    = 1'b0;
        misalign_in = 1'b0;
        store_in    = 1'b0;
        case (uop_in)
            UOP_LB, UOP_LBU: begin
                legal_in = 1'b1;
            end
            UOP_LH, UOP_LHU: begin
                legal_in    = 1'b1;
                misalign_in = ea_in[0];
            end
            UOP_LW: begin
                legal_in    = 1'b1;
                misalign_in = |ea_in[1:0];
            end
            UOP_SB: begin
                legal_in = 1'b1;
                store_in = 1'b1;
            end
            UOP_SH: begin
                legal_in    = 1'b1;
                store_in    = 1'b1;
                misalign_in = ea_in[0];
            end
            UOP_SW: begin
                legal_in    = 1'b1;
                store_in    = 1'b1;
                misalign_in = |ea_in[1:0];
            end
            default: begin
            end
        endcase
    end

    // Place store data on its byte lanes and build the matching strobes.
    always_comb begin
        wstrb_in = 4'b0000;
        wdata_in = 32'h0;
        case (uop_in)
            UOP_SB: begin
                wstrb_in = 4'b0001 << ea_in[1:0];
                wdata_in = {4{st_data_in[7:0]}};
            end
            UOP_SH: begin
                wstrb_in = 4'b0011 << {ea_in[1], 1'b0};
                wdata_in = {2{st_data_in[15:0]}};
            end
            UOP_SW: begin
                wstrb_in = 4'b1111;
                wdata_in = st_data_in;
            end
            default: begin
            end
        endcase
    end

    // Pick the addressed lane out of the read word and extend it.
    always_comb begin
        ld_byte  = 8'h0;
        load_res = 32'h0;
        case (ea_q[1:0])
            2'd0: ld_byte = mem_rdata_in[7:0];
            2'd1: ld_byte = mem_rdata_in[15:8];
            2'd2: ld_byte = mem_rdata_in[23:16];
            default: ld_byte = mem_rdata_in[31:24];
        endcase
        ld_half = ea_q[1] ? mem_rdata_in[31:16] : mem_rdata_in[15:0];
        case (uop_q)
            UOP_LB:  load_res = {{24{ld_byte[7]}}, ld_byte};
            UOP_LBU: load_res = {24'h0, ld_byte};
            UOP_LH:  load_res = {{16{ld_half[15]}}, ld_half};
            UOP_LHU: load_res = {16'h0, ld_half};
            UOP_LW:  load_res = mem_rdata_in;
            default: load_res = 32'h0;
        endcase
    end

    // State register.
    always_ff @(posedge clock_in) begin
        if (!reset_in) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; an ack beats a simultaneous timeout.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = misalign_in ? DONE : REQ;
                end
            end
            REQ: begin
                if (mem_ack_in || timeout_hit) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: latch the access on accept, capture the result on completion.
    always_ff @(posedge clock_in) begin
        if (!reset_in) begin
            uop_q      <= 4'h0;
            ea_q       <= 32'h0;
            tcount     <= 8'h0;
            misalign_q <= 1'b0;
            err_q      <= 1'b0;
            res_q      <= 32'h0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 32'h0;
            wstrb_q    <= 4'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        uop_q      <= uop_in;
                        ea_q       <= ea_in;
                        tcount     <= 8'h0;
                        misalign_q <= misalign_in;
                        err_q      <= 1'b0;
                        if (misalign_in) begin
                            res_q <= ea_in;
                        end else begin
                            we_q    <= store_in;
                            addr_q  <= {ea_in[ADDR_W-1:2], 2'b00};
                            wdata_q <= wdata_in;
                            wstrb_q <= wstrb_in;
                        end
                    end
                end
                REQ: begin
                    if (mem_ack_in) begin
                        res_q <= uop_q[3] ? ea_q : load_res;
                    end else if (timeout_hit) begin
                        res_q <= 32'h0;
                        err_q <= 1'b1;
                    end else begin
                        tcount <= tcount + 8'd1;
                    end
                end
                DONE: begin
                    misalign_q <= 1'b0;
                    err_q      <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_unit.sv
// Directed bench for lsu_mem_unit: a driver issues accesses and pushes the
// expected completion into a scoreboard; a monitor checks every done pulse.
module tb_lsu_mem_unit;

    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 16;

    logic        clock_in = 1'b0;
    logic        reset_in;
    logic        enable_in;
    logic [3:0]  uop_in;
    logic [31:0] a_data_in;
    logic [31:0] b_data_in;
    logic [31:0] st_data_in;
    logic        busy_out;
    logic        done_out;
    logic [31:0] res_data_out;
    logic        misalign_out;
    logic        err_out;
    logic        mem_req_out;
    logic        mem_we_out;
    logic [ADDR_W-1:0] mem_addr_out;
    logic [31:0] mem_wdata_out;
    logic [3:0]  mem_wstrb_out;
    logic        mem_ack_in;
    logic [31:0] mem_rdata_in;

    typedef struct packed {
        logic [31:0] res;
        logic        mis;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;

    lsu_mem_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clock_in(clock_in), .reset_in(reset_in), .enable_in(enable_in),
        .uop_in(uop_in), .a_data_in(a_data_in), .b_data_in(b_data_in),
        .st_data_in(st_data_in), .busy_out(busy_out), .done_out(done_out),
        .res_data_out(res_data_out), .misalign_out(misalign_out),
        .err_out(err_out), .mem_req_out(mem_req_out), .mem_we_out(mem_we_out),
        .mem_addr_out(mem_addr_out), .mem_wdata_out(mem_wdata_out),
        .mem_wstrb_out(mem_wstrb_out), .mem_ack_in(mem_ack_in),
        .mem_rdata_in(mem_rdata_in)
    );

    // 10 time-unit clock.
    always #5 clock_in = ~clock_in;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clock_in) begin
        if (done_out === 1'b1) begin
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checkOutput("sb_res", res_data_out, e.res);
                checkOutput("sb_misalign", {31'h0, misalign_out}, {31'h0, e.mis});
                checkOutput("sb_err", {31'h0, err_out}, {31'h0, e.err});
            end
        end
    end

    // Issue one access. ack_cycle is the REQ cycle (1-based) carrying the ack;
    // 0 means never ack. Ends at the falling edge of the idle cycle after DONE.
    task automatic applyStimulus(input logic [3:0] uop, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] st,
                                 input int ack_cycle, input logic [31:0] rdata,
                                 input logic [31:0] exp_res, input logic exp_mis,
                                 input logic exp_err, input logic [31:0] exp_addr,
                                 input logic [3:0] exp_strb,
                                 input logic [31:0] exp_wdata, input logic exp_we);
        exp_t e;
        int   req_cycles;
        e.res = exp_res;
        e.mis = exp_mis;
        e.err = exp_err;
        sb_q.push_back(e);
        @(negedge clock_in);
        enable_in  = 1'b1;
        uop_in     = uop;
        a_data_in  = a;
        b_data_in  = b;
        st_data_in = st;
        @(posedge clock_in);
        #1;
        enable_in = 1'b0;
        uop_in    = 4'h0;
        if (exp_mis) begin
            @(negedge clock_in);
            checkOutput("mis_no_req", {31'h0, mem_req_out}, 32'd0);
            checkOutput("mis_done_latency", {31'h0, done_out}, 32'd1);
        end else begin
            req_cycles = 0;
            for (int k = 1; k <= 40; k++) begin
                @(negedge clock_in);
                if (mem_req_out !== 1'b1) break;
                req_cycles++;
                checkOutput("bus_addr", mem_addr_out, exp_addr);
                if (k == 1) begin
                    checkOutput("busy_in_req", {31'h0, busy_out}, 32'd1);
                    checkOutput("bus_we", {31'h0, mem_we_out}, {31'h0, exp_we});
                    checkOutput("bus_wstrb", {28'h0, mem_wstrb_out}, {28'h0, exp_strb});
                    checkOutput("bus_wdata", mem_wdata_out, exp_wdata);
                end
                if (k == ack_cycle) begin
                    mem_ack_in   = 1'b1;
                    mem_rdata_in = rdata;
                end
                @(posedge clock_in);
                #1;
                mem_ack_in   = 1'b0;
                mem_rdata_in = 32'h0;
            end
            checkOutput("req_length", req_cycles,
                        (ack_cycle > 0) ? ack_cycle : TIMEOUT);
            checkOutput("done_after_req", {31'h0, done_out}, 32'd1);
        end
        @(negedge clock_in);
        checkOutput("done_one_cycle", {31'h0, done_out}, 32'd0);
        checkOutput("idle_not_busy", {31'h0, busy_out}, 32'd0);
        checkOutput("idle_flags", {30'h0, misalign_out, err_out}, 32'd0);
        checkOutput("res_held", res_data_out, exp_res);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset_in     = 1'b0;
        enable_in    = 1'b0;
        uop_in       = 4'h0;
        a_data_in    = 32'h0;
        b_data_in    = 32'h0;
        st_data_in   = 32'h0;
        mem_ack_in   = 1'b0;
        mem_rdata_in = 32'h0;
        repeat (2) @(posedge clock_in);
        @(negedge clock_in);
        checkOutput("rst_ctrl", {26'h0, busy_out, done_out, misalign_out, err_out,
                                 mem_req_out, mem_we_out}, 32'd0);
        checkOutput("rst_addr", mem_addr_out, 32'h0);
        checkOutput("rst_wdata", mem_wdata_out, 32'h0);
        checkOutput("rst_wstrb", {28'h0, mem_wstrb_out}, 32'h0);
        checkOutput("rst_res", res_data_out, 32'h0);
        reset_in = 1'b1;

        // LB, lane 3 of 0x80FFFFFF sign-extended, ack two cycles after first req
        applyStimulus(4'b0001, 32'h1000, 32'h3, 32'h0, 3, 32'h80FF_FFFF,
                      32'hFFFF_FF80, 1'b0, 1'b0, 32'h1000, 4'b0000, 32'h0, 1'b0);
        // SH to upper half
        applyStimulus(4'b1010, 32'h2000, 32'h2, 32'h1234_ABCD, 1, 32'h0,
                      32'h0000_2002, 1'b0, 1'b0, 32'h2000, 4'b1100, 32'hABCD_ABCD, 1'b1);
        // LW misaligned
        applyStimulus(4'b0011, 32'h1001, 32'h0, 32'h0, 0, 32'h0,
                      32'h0000_1001, 1'b1, 1'b0, 32'h0, 4'b0000, 32'h0, 1'b0);
        // LHU never acked: times out
        applyStimulus(4'b0110, 32'h4000, 32'h2, 32'h0, 0, 32'h0,
                      32'h0, 1'b0, 1'b1, 32'h4000, 4'b0000, 32'h0, 1'b0);
        // LHU acked in the timeout cycle: ack wins
        applyStimulus(4'b0110, 32'h4000, 32'h2, 32'h0, 16, 32'hBEEF_1234,
                      32'h0000_BEEF, 1'b0, 1'b0, 32'h4000, 4'b0000, 32'h0, 1'b0);

        // SW interrupted by a one-cycle reset that also carries an ack
        @(negedge clock_in);
        enable_in  = 1'b1;
        uop_in     = 4'b1100;
        a_data_in  = 32'h3000;
        b_data_in  = 32'h4;
        st_data_in = 32'h1111_2222;
        @(posedge clock_in);
        #1;
        enable_in = 1'b0;
        uop_in    = 4'h0;
        @(negedge clock_in);
        checkOutput("sw_req", {30'h0, mem_req_out, mem_we_out}, 32'd3);
        reset_in     = 1'b0;
        mem_ack_in   = 1'b1;
        mem_rdata_in = 32'h5555_5555;
        @(posedge clock_in);
        #1;
        reset_in     = 1'b1;
        mem_ack_in   = 1'b0;
        mem_rdata_in = 32'h0;
        @(negedge clock_in);
        checkOutput("abort_req", {30'h0, mem_req_out, busy_out}, 32'd0);
        checkOutput("abort_addr", mem_addr_out, 32'h0);
        checkOutput("abort_res", res_data_out, 32'h0);
        repeat (3) @(negedge clock_in);
        checkOutput("abort_idle", {30'h0, busy_out, done_out}, 32'd0);

        // LBU with wrapping EA
        applyStimulus(4'b0101, 32'hFFFF_FFFE, 32'h1, 32'h0, 1, 32'h9A00_0000,
                      32'h0000_009A, 1'b0, 1'b0, 32'hFFFF_FFFC, 4'b0000, 32'h0, 1'b0);
        // LH lower half, negative
        applyStimulus(4'b0010, 32'h100, 32'h0, 32'h0, 2, 32'h0000_8001,
                      32'hFFFF_8001, 1'b0, 1'b0, 32'h100, 4'b0000, 32'h0, 1'b0);
        // SB to lane 1
        applyStimulus(4'b1001, 32'h10, 32'h1, 32'h0000_0055, 1, 32'h0,
                      32'h0000_0011, 1'b0, 1'b0, 32'h10, 4'b0010, 32'h5555_5555, 1'b1);
        // SW aligned
        applyStimulus(4'b1100, 32'h20, 32'h4, 32'hCAFE_F00D, 2, 32'h0,
                      32'h0000_0024, 1'b0, 1'b0, 32'h24, 4'b1111, 32'hCAFE_F00D, 1'b1);
        // SH misaligned
        applyStimulus(4'b1010, 32'h3, 32'h0, 32'h0, 0, 32'h0,
                      32'h0000_0003, 1'b1, 1'b0, 32'h0, 4'b0000, 32'h0, 1'b0);

        // Illegal codes are not accepted; result register keeps the last value
        for (int i = 0; i < 2; i++) begin
            @(negedge clock_in);
            enable_in = 1'b1;
            uop_in    = (i == 0) ? 4'b0100 : 4'b1111;
            a_data_in = 32'h40;
            @(posedge clock_in);
            #1;
            enable_in = 1'b0;
            uop_in    = 4'h0;
            @(negedge clock_in);
            checkOutput("nop_idle", {29'h0, busy_out, mem_req_out, done_out}, 32'd0);
            checkOutput("nop_res", res_data_out, 32'h3);
        end

        repeat (2) @(negedge clock_in);
        checkOutput("sb_drain", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lsu_mem_unit.md
LSU_MEM_UNIT -- requirements
Module: lsu_mem_unit

Interface
REQ-001 Parameter ADDR_W, default 32, width of the memory address bus, legal range 12..32.
REQ-002 Parameter TIMEOUT, default 16, the number of cycles `mem_req_out` may stay high without an ack before the access is aborted; legal range 2..255.
REQ-003 One clock; reset is synchronous and active-low.
REQ-004 Ports, in order:
- `clock_in`  input  1  sole clock, rising edge
- `reset_in`  input  1  synchronous reset, active-low
- `enable_in`  input  1  operation valid
- `uop_in`  input  4  micro-opcode
- `a_data_in`  input  32  base register
- `b_data_in`  input  32  immediate offset
- `st_data_in`  input  32  store data
- `busy_out`  output  1  unit not idle
- `done_out`  output  1  completion pulse
- `res_data_out`  output  32  load result or effective address
- `misalign_out`  output  1  misaligned-access flag, valid with `done_out`
- `err_out`  output  1  timeout flag, valid with `done_out`
- `mem_req_out`  output  1  bus request
- `mem_we_out`  output  1  1 = write
- `mem_addr_out`  output  ADDR_W  word-aligned bus address
- `mem_wdata_out`  output  32  write data
- `mem_wstrb_out`  output  4  byte-lane write strobes
- `mem_ack_in`  input  1  bus acknowledge
- `mem_rdata_in`  input  32  bus read data

Function
REQ-005 Micro-opcodes:
- 0001 LB, 0010 LH, 0011 LW, 0101 LBU, 0110 LHU
- 1001 SB, 1010 SH, 1100 SW
- every other code is a NOP: not accepted, no state change.
REQ-006 The FSM has three states, IDLE, REQ and DONE; the reset state is IDLE.
REQ-007 Accept happens in IDLE when `enable_in`=1 and `uop_in` is legal. The unit latches the uop, store data and EA = (`a_data_in` + `b_data_in`) mod 2^32.
REQ-008 `enable_in` is ignored while `busy_out`=1; `busy_out`=1 in REQ and DONE.
REQ-009 Misalignment: LH/LHU/SH with EA[0]=1, or LW/SW with EA[1:0]≠0.
- The unit goes IDLE→DONE with no bus request.
- `misalign_out`=1 for the DONE cycle.
REQ-010 An aligned accept goes IDLE→REQ.
- In REQ, `mem_req_out`=1.
- `mem_addr_out` = {EA[ADDR_W-1:2], 2'b00}.
- `mem_we_out` = 1 for stores.
- All bus outputs are held stable until the ack.
REQ-011 `mem_ack_in` is sampled only while `mem_req_out`=1; an ack in IDLE or DONE is ignored. An ack in the first REQ cycle is legal.
REQ-012 On an ack the FSM goes REQ→DONE and `mem_req_out` drops at the same edge.
REQ-013 Latency: accept at edge N → `mem_req_out` high in cycle N+1. With the ack sampled at edge N+k (k≥1), `done_out` is high in cycle N+k+1, lasting exactly one cycle. DONE→IDLE is unconditional.
REQ-014 Store strobes and data:
- SB: `mem_wstrb_out` = 4'b0001<<EA[1:0], `mem_wdata_out` = byte replicated ×4.
- SH: 4'b0011<<{EA[1],1'b0}, halfword replicated ×2.
- SW: 4'b1111, data unchanged.
- For loads, strobes=0 and wdata=0.
REQ-015 Load result: the lane selected by EA[1:0] (byte) or EA[1] (half) is captured from `mem_rdata_in` at the ack edge.
- LB/LH: sign-extended.
- LBU/LHU: zero-extended.
- LW: the full word.
REQ-016 For stores and misaligned accesses, `res_data_out` = EA.
REQ-017 `res_data_out` updates only at the transition into DONE and holds until the next DONE.
REQ-018 Timeout: a counter clears on entry to REQ and increments each REQ cycle without an ack. When it reaches TIMEOUT, the FSM goes to DONE with `err_out`=1, `mem_req_out` drops, and `res_data_out` = 0.
REQ-019 An ack in the same cycle the timeout triggers wins: the access is a normal completion and `err_out`=0.
REQ-020 `misalign_out` and `err_out` are 0 outside DONE.
REQ-021 An EA sum overflow wraps silently and is not an error.

Reset
REQ-022 When `reset_in`=0 at a clock edge:
- FSM → IDLE, timeout counter → 0.
- `busy_out`, `done_out`, `misalign_out`, `err_out`, `mem_req_out`, `mem_we_out` → 0.
- `mem_addr_out`, `mem_wdata_out`, `mem_wstrb_out`, `res_data_out` → 0.
REQ-023 A reset mid-transaction abandons the access: `mem_req_out` is low in the cycle after the reset edge, and no `done_out` follows.
REQ-024 Reset takes precedence over `enable_in` and `mem_ack_in` in the same cycle.

Verification
REQ-025 LB, A=0x1000, B=0x3, rdata=0x80FF_FFFF, ack 2 cycles after req → `mem_addr_out`=0x1000, `res_data_out`=0xFFFF_FF80, `done_out` pulse once.
REQ-026 SH, A=0x2000, B=0x2, st_data=0x1234_ABCD, ack → `mem_wstrb_out`=4'b1100, `mem_wdata_out`=0xABCD_ABCD, `mem_we_out`=1, `res_data_out`=0x2002.
REQ-027 LW, A=0x1001, B=0 → no `mem_req_out`, `done_out`=1 with `misalign_out`=1 in the cycle after accept, `res_data_out`=0x1001.
REQ-028 LHU, TIMEOUT=16, never ack → `mem_req_out` high for exactly 16 cycles, then `done_out`=1 and `err_out`=1 with `res_data_out`=0; repeat with ack on the 16th cycle → `err_out`=0.
REQ-029 `reset_in`=0 for one cycle during REQ of an SW → `mem_req_out`=0 next cycle, no `done_out`; a following LBU at EA=0xFFFF_FFFF (A=0xFFFF_FFFE, B=1) runs normally.
